digit_scan: RTL

Time-multiplexed scan controller for a 4-digit active-low seven-segment display. Holds a 4-digit BCD value, steps through the digits at a programmable refresh rate, and drives one 4-bit digit code plus the matching active-low digit enable. Sits directly upstream of the BCD-to-seven-segment decoder: `digit` feeds the decoder's 4-bit input, and `an` drives the common anodes. New values enter through a valid/ready handshake and are committed only at frame boundaries, so a frame never mixes old and new digits.

---
 rtl/digit_scan.sv | 116 +++++++++++
 1 files changed

// File: rtl/digit_scan.sv
// digit_scan: time-multiplexed scan controller for a 4-digit active-low
// seven-segment display. It holds a BCD value and steps through the digits at a
// programmable rate. New values are accepted through a valid/ready handshake.
// They are swapped into the displayed value only at frame boundaries.
module digit_scan #(
    parameter int TICK_DIV = 50000,
    parameter int CNT_W    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_valid,
    input  logic [15:0] load_data,
    output logic        load_ready,
    input  logic        blank_lz,
    output logic [3:0]  digit,
    output logic [3:0]  an,
    output logic        frame
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic [1:0]       idx_reg;
    logic [15:0]      active_reg;
    logic [15:0]      pending_reg;
    logic             pend_full_reg;
    logic [3:0]       digit_reg;
    logic [3:0]       an_reg;
    logic             frame_reg;

    logic             tick;
    logic             boundary;
    logic             accept;
    logic             commit;
    logic [1:0]       idx_next;
    logic [15:0]      active_next;
    logic [3:0]       digit_next;
    logic [3:0]       nib [4];
    logic [3:0]       upper_zero;

    assign tick       = (cnt_reg == CNT_MAX);
    assign boundary   = tick && (idx_reg == 2'd3);
    // Accept and commit are mutually exclusive through pend_full_reg.
    assign accept     = load_valid && !pend_full_reg;
    assign commit     = boundary && pend_full_reg;
    assign idx_next   = idx_reg + 2'd1;
    // Digit selection looks at the post-commit value, so slot 0 of a new
    // frame already shows the freshly committed digits.
    assign active_next = commit ? pending_reg : active_reg;

    // Per-slot nibble and "this slot and everything above it is zero" flags.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slot
            assign nib[gi]        = active_next[4*gi +: 4];
            assign upper_zero[gi] = (active_next[15:4*gi] == '0);
        end
    endgenerate

    // Choose the code for the slot about to be shown, applying leading-zero blanking.
    always_comb begin
        digit_next = nib[idx_next];
        if (blank_lz && (idx_next != 2'd0) && upper_zero[idx_next]) begin
            digit_next = 4'hF;
        end
    end

    // Prescaler and scan index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
            idx_reg <= 2'd0;
        end else if (tick) begin
            cnt_reg <= '0;
            idx_reg <= idx_next;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // Pending buffer handshake and frame-boundary commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_reg    <= 16'h0000;
            pending_reg   <= 16'h0000;
            pend_full_reg <= 1'b0;
        end else if (commit) begin
            active_reg    <= pending_reg;
            pend_full_reg <= 1'b0;
        end else if (accept) begin
            pending_reg   <= load_data;
            pend_full_reg <= 1'b1;
        end
    end

    // Registered digit/anode outputs change together on tick; frame pulses once per boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_reg <= 4'h0;
            an_reg    <= 4'b1110;
            frame_reg <= 1'b0;
        end else begin
            frame_reg <= boundary;
            if (tick) begin
                digit_reg <= digit_next;
                an_reg    <= ~(4'b0001 << idx_next);
            end
        end
    end

    assign load_ready = !pend_full_reg;
    assign digit      = digit_reg;
    assign an         = an_reg;
    assign frame      = frame_reg;

endmodule
